// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed hex display driver.
// Time-slices one active-low digit enable at a time over a latched 32-bit value.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        display_we,
  input  logic [31:0] display,
  input  logic        halt,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [31:0] shown
);

  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shown_q, shown_d;
  logic        wrap;

  always_comb begin
    wrap    = (cnt_q == DIV_MAX);
    cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d   = wrap ? idx_q + 3'd1 : idx_q;
    shown_d = display_we ? display : shown_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
    end
  end

  logic [4:0]  base;
  logic [3:0]  nib;
  logic [31:0] upper;
  logic        blank;
  logic [6:0]  seg_hi;

  always_comb begin
    base  = {idx_q, 2'b00};
    nib   = shown_q[base +: 4];
    upper = shown_q >> base;
    // Digit 0 always lights so a zero value still shows "0".
    blank = BLANK_LZ && (idx_q != 3'd0) && (upper == 32'd0);
  end

  always_comb begin
    seg_hi = 7'h00;
    unique case (nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      4'hF: seg_hi = 7'h71;
    endcase
  end

  always_comb begin
    an    = blank ? 8'hFF : ~(8'b1 << idx_q);
    seg   = blank ? 7'h7F : ~seg_hi;
    dp    = ~((idx_q == 3'd0) && halt);
    shown = shown_q;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit stays selected (legal 1..65535).
REQ-002 SHALL have parameter BLANK_LZ, default 1, 1 = leading-zero blanking enabled.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 display_we  input  1  capture strobe from the CPU syscall path, high for one cycle per display syscall.
REQ-006 display  input  32  value to show, sampled when display_we=1.
REQ-007 halt  input  1  CPU halted flag, level.
REQ-008 an  output  8  digit enables, active-low, an[i] = hex digit i (digit 0 = display[3:0]).
REQ-009 seg  output  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 shown  output  32  currently latched display value.

Function
REQ-012 shown SHALL load display on a rising edge with display_we=1 and hold otherwise; new value visible the following cycle.
REQ-013 Prescaler cnt (16 bit) SHALL count 0..SCAN_DIV-1 and wrap to 0; idx (3 bit) SHALL increment on the wrap edge only, 7 wrapping to 0.
REQ-014 With SCAN_DIV=1, idx SHALL advance every cycle.
REQ-015 an, seg, dp SHALL be combinational decodes of the registers idx, shown and the halt input; no other latency.
REQ-016 Active nibble SHALL be shown[4*idx+3:4*idx].
REQ-017 Active-high segment codes (gfedcba) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; seg SHALL be the bitwise inverse.
REQ-018 Digit idx SHALL be blanked when BLANK_LZ=1, idx!=0 and shown[31:4*idx]==0; digit 0 SHALL never be blanked.
REQ-019 Unblanked digit: an = ~(8'b1<<idx); blanked digit: an = 8'hFF, seg = 7'h7F.
REQ-020 At most one an bit SHALL be low at any time.
REQ-021 dp SHALL be 0 only when idx==0 and halt==1, else 1.
REQ-022 display_we coinciding with a prescaler wrap SHALL apply both: new shown and new idx in the same next cycle.
REQ-023 display_we SHALL NOT reset cnt or idx.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force cnt=0, idx=0, shown=0.
REQ-025 Outputs during and after reset: an=8'hFE, seg=7'h40, dp=1 (halt=0), shown=0.
REQ-026 Reset asserted mid-scan SHALL abort the current digit period; scanning restarts at idx 0 with a full SCAN_DIV period after release.

Verification (SCAN_DIV=4, BLANK_LZ=1 unless stated)
REQ-027 Reset only -> an=FE, seg=40, dp=1, shown=00000000; idx 1..7 slots give an=FF (blanked).
REQ-028 Pulse display_we with 0x1234ABCD -> over 32 cycles slots 0..7 give an=FE,FD,FB,F7,EF,DF,BF,7F and seg=21,46,03,08,19,30,24,79; each slot held 4 cycles.
REQ-029 Load 0x000000A0 -> slot0 seg=40, slot1 an=FD seg=08, slots 2..7 an=FF seg=7F; with BLANK_LZ=0 slots 2..7 show seg=40.
REQ-030 halt=1 -> dp=0 exactly in slot 0, dp=1 in slots 1..7; halt=0 -> dp=1 always.
REQ-031 display_we on the cnt=3 edge of slot 2 with 0xFFFFFFFF -> next cycle idx=3, an=F7, seg=0E; assert rst at cnt=2 of slot 5 -> an=FE, seg=40, shown=0 before the next clock edge.
